// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port register file with two write ports,
// any number of combinational read ports, optional write-to-read bypass and
// a per-entry pending-write scoreboard used by decode to stall on operands.
module regfile_mp #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 32,
    parameter int READ_PORTS = 2,
    parameter int ZERO_REG   = 1,
    parameter int BYPASS     = 1,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [READ_PORTS*AW-1:0]         rdNum,
    output logic [READ_PORTS*DATA_WIDTH-1:0] rdData,
    output logic [READ_PORTS-1:0]            rdBusy,
    input  logic [1:0]                       wrEnable,
    input  logic [2*AW-1:0]                  wrNum,
    input  logic [2*DATA_WIDTH-1:0]          wrData,
    input  logic                             issueEnable,
    input  logic [AW-1:0]                    issueNum,
    output logic [AW:0]                      busyCount
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic [DEPTH-1:0]      busy_q;
    logic [DEPTH-1:0]      busy_d;
    logic [AW:0]           busy_count_q;
    logic [AW:0]           busy_count_d;

    logic [AW-1:0]         wr_num0;
    logic [AW-1:0]         wr_num1;
    logic [DATA_WIDTH-1:0] wr_data0;
    logic [DATA_WIDTH-1:0] wr_data1;

    logic [AW-1:0]         rd_addr;
    logic [DATA_WIDTH-1:0] rd_value;
    logic                  rd_pending;

    assign wr_num0   = wrNum[0 +: AW];
    assign wr_num1   = wrNum[AW +: AW];
    assign wr_data0  = wrData[0 +: DATA_WIDTH];
    assign wr_data1  = wrData[DATA_WIDTH +: DATA_WIDTH];
    assign busyCount = busy_count_q;

    // Next storage contents: WP0 applied first so WP1 wins on a shared entry.
    always_comb begin
        mem_d = mem_q;
        if (wrEnable[0]) begin
            mem_d[wr_num0] = wr_data0;
        end
        if (wrEnable[1]) begin
            mem_d[wr_num1] = wr_data1;
        end
        if (ZERO_REG != 0) begin
            mem_d[0] = '0;
        end
    end

    // Next scoreboard: write-back clears, then a new issue re-sets (new producer wins).
    always_comb begin
        busy_d = busy_q;
        if (wrEnable[0]) begin
            busy_d[wr_num0] = 1'b0;
        end
        if (wrEnable[1]) begin
            busy_d[wr_num1] = 1'b0;
        end
        if (issueEnable) begin
            busy_d[issueNum] = 1'b1;
        end
        if (ZERO_REG != 0) begin
            busy_d[0] = 1'b0;
        end
    end

    // Population count of the next busy vector so the count tracks the bits on the same edge.
    always_comb begin
        busy_count_d = '0;
        for (int n = 0; n < DEPTH; n++) begin
            busy_count_d = busy_count_d + (AW+1)'(busy_d[n]);
        end
    end

    // Storage, scoreboard and count registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int n = 0; n < DEPTH; n++) begin
                mem_q[n] <= '0;
            end
            busy_q       <= '0;
            busy_count_q <= '0;
        end else begin
            mem_q        <= mem_d;
            busy_q       <= busy_d;
            busy_count_q <= busy_count_d;
        end
    end

    // Combinational read ports; reset forces zeros so bypass cannot leak data while held.
    always_comb begin
        rdData     = '0;
        rdBusy     = '0;
        rd_addr    = '0;
        rd_value   = '0;
        rd_pending = 1'b0;
        for (int i = 0; i < READ_PORTS; i++) begin
            rd_addr    = rdNum[i*AW +: AW];
            rd_value   = mem_q[rd_addr];
            rd_pending = busy_q[rd_addr];
            if (BYPASS != 0) begin
                if (wrEnable[0] && (wr_num0 == rd_addr)) begin
                    rd_value   = wr_data0;
                    rd_pending = 1'b0;
                end
                if (wrEnable[1] && (wr_num1 == rd_addr)) begin
                    rd_value   = wr_data1;
                    rd_pending = 1'b0;
                end
            end
            if ((ZERO_REG != 0) && (rd_addr == '0)) begin
                rd_value   = '0;
                rd_pending = 1'b0;
            end
            if (!rst) begin
                rd_value   = '0;
                rd_pending = 1'b0;
            end
            rdData[i*DATA_WIDTH +: DATA_WIDTH] = rd_value;
            rdBusy[i]                          = rd_pending;
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed scenarios followed by randomized traffic, checked
// against an array-based reference model of the register file and scoreboard.
module tb_regfile_mp;

    localparam int DW    = 32;
    localparam int DEPTH = 32;
    localparam int AW    = 5;
    localparam int RP    = 2;

    logic              clk;
    logic              rst;
    logic [RP*AW-1:0]  rdNum;
    logic [RP*DW-1:0]  rdData;
    logic [RP-1:0]     rdBusy;
    logic [1:0]        wrEnable;
    logic [2*AW-1:0]   wrNum;
    logic [2*DW-1:0]   wrData;
    logic              issueEnable;
    logic [AW-1:0]     issueNum;
    logic [AW:0]       busyCount;

    int numVectors = 0;
    int numMiscompares = 0;

    logic [DW-1:0] modelMem [DEPTH];
    bit            modelBusy [DEPTH];

    regfile_mp #(
        .DATA_WIDTH(DW),
        .DEPTH(DEPTH),
        .READ_PORTS(RP),
        .ZERO_REG(1),
        .BYPASS(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rdNum(rdNum),
        .rdData(rdData),
        .rdBusy(rdBusy),
        .wrEnable(wrEnable),
        .wrNum(wrNum),
        .wrData(wrData),
        .issueEnable(issueEnable),
        .issueNum(issueNum),
        .busyCount(busyCount)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts every check and reports any difference.
    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        numVectors++;
        if (observed !== expected) begin
            numMiscompares++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic resetModel();
        for (int n = 0; n < DEPTH; n++) begin
            modelMem[n]  = '0;
            modelBusy[n] = 1'b0;
        end
    endtask

    // Expected read value: reset zeros, r0 is zero, newest same-cycle write wins, else storage.
    function automatic logic [DW-1:0] expData(input logic [AW-1:0] a);
        if (!rst || a == 0) return '0;
        if (wrEnable[1] && wrNum[AW +: AW] == a) return wrData[DW +: DW];
        if (wrEnable[0] && wrNum[0 +: AW] == a) return wrData[0 +: DW];
        return modelMem[a];
    endfunction

    function automatic logic expBusy(input logic [AW-1:0] a);
        if (!rst || a == 0) return 1'b0;
        if (wrEnable[1] && wrNum[AW +: AW] == a) return 1'b0;
        if (wrEnable[0] && wrNum[0 +: AW] == a) return 1'b0;
        return modelBusy[a];
    endfunction

    function automatic int expCount();
        int c = 0;
        for (int n = 0; n < DEPTH; n++) c += int'(modelBusy[n]);
        return c;
    endfunction

    task automatic checkAgainstModel();
        for (int p = 0; p < RP; p++) begin
            checkOutput($sformatf("rdData[%0d]", p), 64'(rdData[p*DW +: DW]), 64'(expData(rdNum[p*AW +: AW])));
            checkOutput($sformatf("rdBusy[%0d]", p), 64'(rdBusy[p]), 64'(expBusy(rdNum[p*AW +: AW])));
        end
        checkOutput("busyCount", 64'(busyCount), 64'(expCount()));
    endtask

    // Drive one cycle's inputs after the falling edge and compare the combinational view.
    task automatic applyStimulus(input int rn0, input int rn1, input logic [1:0] we,
                                 input int wn0, input int wn1, input logic [DW-1:0] wd0,
                                 input logic [DW-1:0] wd1, input logic ie, input int in);
        @(negedge clk);
        rdNum       = {AW'(rn1), AW'(rn0)};
        wrEnable    = we;
        wrNum       = {AW'(wn1), AW'(wn0)};
        wrData      = {wd1, wd0};
        issueEnable = ie;
        issueNum    = AW'(in);
        #1;
        checkAgainstModel();
    endtask

    // Advance to the rising edge and apply the architectural update rules to the model.
    task automatic tick();
        logic [AW-1:0] a0, a1, ai;
        @(posedge clk);
        if (!rst) begin
            resetModel();
            return;
        end
        a0 = wrNum[0 +: AW];
        a1 = wrNum[AW +: AW];
        ai = issueNum;
        if (wrEnable[0] && a0 != 0) modelMem[a0] = wrData[0 +: DW];
        if (wrEnable[1] && a1 != 0) modelMem[a1] = wrData[DW +: DW];
        if (wrEnable[0]) modelBusy[a0] = 1'b0;
        if (wrEnable[1]) modelBusy[a1] = 1'b0;
        if (issueEnable && ai != 0) modelBusy[ai] = 1'b1;
    endtask

    task automatic readOnly(input int rn0, input int rn1);
        applyStimulus(rn0, rn1, 2'b00, 0, 0, '0, '0, 1'b0, 0);
    endtask

    initial begin
        int a0, a1;
        rst         = 1'b0;
        rdNum       = {AW'(6), AW'(5)};
        wrEnable    = '0;
        wrNum       = '0;
        wrData      = '0;
        issueEnable = 1'b0;
        issueNum    = '0;
        resetModel();
        #2;
        checkOutput("reset_busyCount", 64'(busyCount), 64'd0);
        checkOutput("reset_rdData", 64'(rdData), 64'd0);
        checkOutput("reset_rdBusy", 64'(rdBusy), 64'd0);
        @(negedge clk);
        rst = 1'b1;

        // Basic write then read back on the following cycle.
        applyStimulus(5, 6, 2'b01, 5, 0, 32'hDEADBEEF, '0, 1'b0, 0);
        tick();
        readOnly(5, 6);
        checkOutput("r5_readback", 64'(rdData[0 +: DW]), 64'hDEADBEEF);
        checkOutput("r6_untouched", 64'(rdData[DW +: DW]), 64'd0);
        tick();

        // Both write ports on r7: WP1 wins, also through the bypass.
        applyStimulus(7, 7, 2'b11, 7, 7, 32'h11, 32'h22, 1'b0, 0);
        checkOutput("r7_bypass", 64'(rdData[0 +: DW]), 64'h22);
        tick();
        readOnly(7, 5);
        checkOutput("r7_stored", 64'(rdData[0 +: DW]), 64'h22);
        tick();

        // Hardwired zero entry ignores writes and issues.
        applyStimulus(0, 0, 2'b01, 0, 0, 32'hFFFFFFFF, '0, 1'b1, 0);
        checkOutput("r0_bypass_blocked", 64'(rdData[0 +: DW]), 64'd0);
        tick();
        readOnly(0, 0);
        checkOutput("r0_data", 64'(rdData[0 +: DW]), 64'd0);
        checkOutput("r0_busy", 64'(rdBusy[0]), 64'd0);
        checkOutput("r0_count", 64'(busyCount), 64'd0);
        tick();

        // Issue r3, then retire it through WP1 with bypass masking busy.
        applyStimulus(3, 4, 2'b00, 0, 0, '0, '0, 1'b1, 3);
        tick();
        readOnly(3, 4);
        checkOutput("r3_busy", 64'(rdBusy[0]), 64'd1);
        checkOutput("r3_count", 64'(busyCount), 64'd1);
        tick();
        applyStimulus(3, 4, 2'b10, 0, 3, '0, 32'h5A, 1'b0, 0);
        checkOutput("r3_wb_busy", 64'(rdBusy[0]), 64'd0);
        checkOutput("r3_wb_data", 64'(rdData[0 +: DW]), 64'h5A);
        tick();
        readOnly(3, 4);
        checkOutput("r3_count_clear", 64'(busyCount), 64'd0);
        tick();

        // Issue and write-back on an already busy r9 in the same cycle: stays busy.
        applyStimulus(9, 1, 2'b00, 0, 0, '0, '0, 1'b1, 9);
        tick();
        applyStimulus(8, 1, 2'b01, 9, 0, 32'h99, '0, 1'b1, 9);
        tick();
        readOnly(9, 1);
        checkOutput("r9_still_busy", 64'(rdBusy[0]), 64'd1);
        checkOutput("r9_data", 64'(rdData[0 +: DW]), 64'h99);
        checkOutput("r9_count", 64'(busyCount), 64'd1);
        tick();
        applyStimulus(9, 1, 2'b01, 9, 0, 32'h9A, '0, 1'b0, 0);
        tick();

        // Consecutive issues build the count, then reset mid-cycle clears it immediately.
        applyStimulus(1, 2, 2'b00, 0, 0, '0, '0, 1'b1, 1);
        tick();
        applyStimulus(1, 2, 2'b00, 0, 0, '0, '0, 1'b1, 2);
        checkOutput("count_1", 64'(busyCount), 64'd1);
        tick();
        applyStimulus(1, 4, 2'b00, 0, 0, '0, '0, 1'b1, 4);
        checkOutput("count_2", 64'(busyCount), 64'd2);
        tick();
        applyStimulus(5, 1, 2'b01, 7, 0, 32'hCAFE, '0, 1'b1, 6);
        checkOutput("count_3", 64'(busyCount), 64'd3);
        #1 rst = 1'b0;
        #1;
        checkOutput("midreset_count", 64'(busyCount), 64'd0);
        checkOutput("midreset_rdBusy", 64'(rdBusy), 64'd0);
        checkOutput("midreset_rdData", 64'(rdData), 64'd0);
        resetModel();
        @(negedge clk);
        wrEnable    = '0;
        issueEnable = 1'b0;
        rst         = 1'b1;
        readOnly(5, 7);
        checkOutput("postreset_r5", 64'(rdData[0 +: DW]), 64'd0);
        tick();

        // Randomized traffic, addresses biased to a small window to provoke collisions.
        for (int cyc = 0; cyc < 400; cyc++) begin
            a0 = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 7) : $urandom_range(0, DEPTH-1);
            a1 = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 7) : $urandom_range(0, DEPTH-1);
            applyStimulus(a0, a1, 2'($urandom_range(0, 3)),
                          $urandom_range(0, 7), $urandom_range(0, 7),
                          DW'($urandom), DW'($urandom),
                          1'($urandom_range(0, 1)), $urandom_range(0, 9));
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", numVectors, numMiscompares);
        $finish;
    end

endmodule
